// File: rtl/apb_master.sv
// APB master: takes one local command at a time and runs it as a SETUP/ACCESS transfer.
// An ACCESS phase that waits too long is aborted with an error response.
module apb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    output logic [4:0] TPS
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t     state_q;
    logic       cmd_ready_q;
    logic       psel_q;
    logic       penable_q;
    logic       pwrite_q;
    logic [7:0] paddr_q;
    logic [7:0] pwdata_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_rdata_q;
    logic       rsp_err_q;
    logic [7:0] wait_cnt_q;
    logic       pready_q;
    logic       wait_last;

    // High on the cycle that would be the TIMEOUT-th consecutive wait state.
    assign wait_last = (wait_cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'h00;
            pwdata_q    <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            wait_cnt_q  <= 8'h00;
            pready_q    <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            pready_q    <= PREADY;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= S_SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= cmd_write;
                        paddr_q     <= cmd_addr;
                        pwdata_q    <= cmd_wdata;
                        wait_cnt_q  <= 8'h00;
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    // A ready slave wins over a timeout firing in the same cycle.
                    if (psel_q && penable_q && PREADY) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? 8'h00 : PRDATA;
                        rsp_err_q   <= PSLVERR;
                    end else if (wait_last) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= 8'h00;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    // PREADY is shown one cycle late so no APB input reaches an output combinationally.
    assign TPS       = {pready_q, penable_q, psel_q, pwrite_q, PCLK};

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and random transfers against a transaction-level model
// that predicts the bus phases, response cycle and response contents of each command.
module tb_apb_master;

    localparam int TO = 16;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;
    logic [4:0] TPS;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_rdata = 8'h00;
    logic       exp_err = 1'b0;

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .TPS(TPS)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bus(input string ph, input logic pen, input logic wr,
                             input logic [7:0] addr, input logic [7:0] wdata);
        chk({ph, "_psel"}, PSEL, 1'b1);
        chk({ph, "_penable"}, PENABLE, pen);
        chk({ph, "_pwrite"}, PWRITE, wr);
        chk({ph, "_paddr"}, PADDR, addr);
        chk({ph, "_pwdata"}, PWDATA, wdata);
        chk({ph, "_cmd_ready"}, cmd_ready, 1'b0);
        chk({ph, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({ph, "_tps"}, TPS[3:0], {pen, 1'b1, wr, 1'b0});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        chk({tag, "_psel"}, PSEL, 1'b0);
        chk({tag, "_penable"}, PENABLE, 1'b0);
        chk({tag, "_pwrite"}, PWRITE, 1'b0);
        chk({tag, "_paddr"}, PADDR, 8'h00);
        chk({tag, "_pwdata"}, PWDATA, 8'h00);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 8'h00);
    endtask

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_write = 1'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_wdata = 8'($urandom);
    endtask

    task automatic idle_cycle();
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        PREADY    = 1'($urandom);
        PSLVERR   = 1'($urandom);
        @(negedge PCLK);
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        chk("idle_psel", PSEL, 1'b0);
        chk("idle_penable", PENABLE, 1'b0);
        chk("idle_cmd_ready", cmd_ready, 1'b1);
        chk("idle_rdata_hold", rsp_rdata, exp_rdata);
        chk("idle_err_hold", rsp_err, exp_err);
    endtask

    // Called in an idle (or response) cycle away from the clock edge. The slave holds
    // PREADY low for 'waits' ACCESS cycles; rst_at > 0 pulses PRESET in that ACCESS cycle.
    task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] rdata, input int waits, input logic err,
                          input int rst_at);
        int  k;
        bit  was_reset;
        logic timeout;
        k = (waits >= TO) ? TO : waits + 1;
        was_reset = 1'b0;
        timeout = (waits >= TO);
        chk("accept_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;

        @(posedge PCLK); #1;
        scramble_cmd();
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = 8'($urandom);
        @(negedge PCLK);
        check_bus("setup", 1'b0, wr, addr, wdata);

        for (int j = 1; j <= k; j++) begin
            @(posedge PCLK); #1;
            scramble_cmd();
            PREADY  = (j > waits);
            PSLVERR = (j > waits) ? err : 1'b1;
            PRDATA  = (j > waits) ? rdata : 8'($urandom);
            PRESET  = (j == rst_at);
            @(negedge PCLK);
            check_bus("access", 1'b1, wr, addr, wdata);
            if (j == rst_at) begin
                was_reset = 1'b1;
                break;
            end
        end

        @(posedge PCLK); #1;
        PRESET    = 1'b0;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        @(negedge PCLK);
        if (was_reset) begin
            exp_rdata = 8'h00;
            exp_err   = 1'b0;
            check_reset_vals("midrst");
        end else begin
            exp_err   = timeout ? 1'b1 : err;
            exp_rdata = (timeout || wr) ? 8'h00 : rdata;
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_err", rsp_err, exp_err);
            chk("rsp_psel", PSEL, 1'b0);
            chk("rsp_penable", PENABLE, 1'b0);
            chk("rsp_cmd_ready", cmd_ready, 1'b1);
        end
    endtask

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h5A;
        cmd_wdata = 8'hC3;
        PRDATA    = 8'h00;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check_reset_vals("reset");
        @(posedge PCLK); #1;
        PRESET    = 1'b0;
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check_reset_vals("post_reset");

        do_txn(1'b0, 8'h04, 8'h00, 8'hA5, 0, 1'b0, 0);
        idle_cycle();
        do_txn(1'b1, 8'h10, 8'h3C, 8'h77, 3, 1'b0, 0);
        idle_cycle();
        do_txn(1'b0, 8'h20, 8'h00, 8'h5A, 2, 1'b1, 0);
        idle_cycle();
        do_txn(1'b0, 8'h30, 8'h00, 8'h11, 16, 1'b0, 0);
        idle_cycle();
        do_txn(1'b0, 8'h31, 8'h00, 8'h22, 15, 1'b0, 0);
        idle_cycle();
        do_txn(1'b0, 8'h01, 8'h00, 8'hC3, 0, 1'b0, 0);
        do_txn(1'b1, 8'h02, 8'h66, 8'hFF, 0, 1'b0, 0);
        idle_cycle();
        do_txn(1'b0, 8'h40, 8'h00, 8'hEE, 5, 1'b0, 3);
        idle_cycle();
        do_txn(1'b0, 8'h41, 8'h00, 8'h99, 0, 1'b0, 0);
        idle_cycle();
        do_txn(1'b1, 8'h42, 8'h12, 8'h34, 2, 1'b0, 3);
        idle_cycle();

        for (int n = 0; n < 60; n++) begin
            int w;
            int r;
            int ra;
            r  = int'($urandom_range(0, 9));
            w  = (r < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 18));
            ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), w,
                   1'($urandom), ra);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
